id_ex_stage: RTL

//  Decode->Execute pipeline register directly downstream of the 16x32 register file.

---
 rtl/id_ex_stage_pkg.sv | 26 ++
 rtl/id_ex_stage_fwd_mux.sv | 53 +++++
 rtl/id_ex_stage.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_pkg
//   Shared types and constants for the Decode->Execute pipeline register.
//   ctrl_t   : decoded control bundle carried from D into E
//   REG_PC   : architectural register index that reads as PC+8
//   CTRL_NOP : all-zero control bundle used for bubbles and reset
//   Optional feature macro used by the files importing this package:
//   ID_EX_FWD_EN (operand forwarding from MEM/WB).
// ---------------------------------------------------------------------------
package id_ex_pkg;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic [1:0] alu_ctrl;
    logic [1:0] flag_write;
    logic [3:0] cond;
  } ctrl_t;

  localparam logic [3:0] REG_PC   = 4'd15;
  localparam ctrl_t      CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
//   Selects the freshest value of one execute operand. A pending MEM-stage
//   write to the same register wins over a pending WB-stage write, which
//   wins over the value captured at decode. R15 is never forwarded because
//   its value is the PC+8 substitute, not a register-file entry.
//   Instantiated by id_ex_stage only when ID_EX_FWD_EN is defined.
// Ports
//   i_ra_e        in  AW  source address held in E
//   i_op_e        in  DW  operand captured in E
//   i_result_m    in  DW  MEM-stage result
//   i_result_w    in  DW  WB-stage result
//   i_wa_m/i_wa_w in  AW  MEM / WB destination addresses
//   i_reg_write_m in  1   MEM stage will write i_wa_m
//   i_reg_write_w in  1   WB stage will write i_wa_w
//   o_src         out DW  resolved operand
// ---------------------------------------------------------------------------
module fwd_mux
  import id_ex_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic [AW-1:0] i_ra_e,
  input  logic [DW-1:0] i_op_e,
  input  logic [DW-1:0] i_result_m,
  input  logic [DW-1:0] i_result_w,
  input  logic [AW-1:0] i_wa_m,
  input  logic [AW-1:0] i_wa_w,
  input  logic          i_reg_write_m,
  input  logic          i_reg_write_w,
  output logic [DW-1:0] o_src
);

  logic w_not_pc;
  logic w_hit_m;
  logic w_hit_w;

  assign w_not_pc = (i_ra_e != AW'(REG_PC));
  assign w_hit_m  = i_reg_write_m && (i_wa_m == i_ra_e) && w_not_pc;
  assign w_hit_w  = i_reg_write_w && (i_wa_w == i_ra_e) && w_not_pc;

  // MEM is younger than WB, so its result takes priority on a double hit.
  always_comb begin
    o_src = i_op_e;
    if (w_hit_m) begin
      o_src = i_result_m;
    end else if (w_hit_w) begin
      o_src = i_result_w;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   Decode->Execute pipeline register sitting right after the 16x32 register
//   file. Captures operands, addresses, immediate and decoded control every
//   clock, substitutes PC+8 for reads of R15, and raises a load-use hazard
//   request back to fetch/decode.
//   Optional macro ID_EX_FWD_EN: adds MEM/WB forwarding ports and resolves
//   the execute operands against them. Without it the execute operands are
//   the registered operands directly.
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_stall_e             hold every E register this cycle
//   i_flush_e             load a bubble (beats stall)
//   i_valid_d             D holds a real instruction
//   i_ra1_d, i_ra2_d      source addresses presented to the register file
//   i_rd1_d, i_rd2_d      register file read data
//   i_wa_d                destination register
//   i_imm_d               extended immediate
//   i_pc_plus8_d          value architecturally read as R15
//   i_ctrl_d              decoded control
//   o_valid_e             E instruction valid
//   o_src_a_e, o_src_b_e  execute operands
//   o_ra1_e, o_ra2_e,
//   o_wa_e                registered addresses
//   o_imm_e               registered immediate
//   o_ctrl_e              registered control (zero when invalid)
//   o_lu_stall_d          load-use hazard request
//   i_result_m/w, i_wa_m/w, i_reg_write_m/w   forwarding inputs (ID_EX_FWD_EN)
// ---------------------------------------------------------------------------
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_stall_e,
  input  logic          i_flush_e,
  input  logic          i_valid_d,
  input  logic [AW-1:0] i_ra1_d,
  input  logic [AW-1:0] i_ra2_d,
  input  logic [DW-1:0] i_rd1_d,
  input  logic [DW-1:0] i_rd2_d,
  input  logic [AW-1:0] i_wa_d,
  input  logic [DW-1:0] i_imm_d,
  input  logic [DW-1:0] i_pc_plus8_d,
  input  ctrl_t         i_ctrl_d,
`ifdef ID_EX_FWD_EN
  input  logic [DW-1:0] i_result_m,
  input  logic [DW-1:0] i_result_w,
  input  logic [AW-1:0] i_wa_m,
  input  logic [AW-1:0] i_wa_w,
  input  logic          i_reg_write_m,
  input  logic          i_reg_write_w,
`endif
  output logic          o_valid_e,
  output logic [DW-1:0] o_src_a_e,
  output logic [DW-1:0] o_src_b_e,
  output logic [AW-1:0] o_ra1_e,
  output logic [AW-1:0] o_ra2_e,
  output logic [AW-1:0] o_wa_e,
  output logic [DW-1:0] o_imm_e,
  output ctrl_t         o_ctrl_e,
  output logic          o_lu_stall_d
);

  logic          r_valid_e;
  logic [DW-1:0] r_op1_e;
  logic [DW-1:0] r_op2_e;
  logic [AW-1:0] r_ra1_e;
  logic [AW-1:0] r_ra2_e;
  logic [AW-1:0] r_wa_e;
  logic [DW-1:0] r_imm_e;
  ctrl_t         r_ctrl_e;

  logic [DW-1:0] w_op1_d;
  logic [DW-1:0] w_op2_d;

  // R15 is not stored in the register file; its architectural value is PC+8.
  assign w_op1_d = (i_ra1_d == AW'(REG_PC)) ? i_pc_plus8_d : i_rd1_d;
  assign w_op2_d = (i_ra2_d == AW'(REG_PC)) ? i_pc_plus8_d : i_rd2_d;

  // Priority: reset, then flush (bubble, even if stalled), then stall (hold),
  // then normal capture. A flush leaves the data registers as they were;
  // they are meaningless once valid drops, and holding them saves toggling.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid_e <= 1'b0;
      r_op1_e   <= '0;
      r_op2_e   <= '0;
      r_ra1_e   <= '0;
      r_ra2_e   <= '0;
      r_wa_e    <= '0;
      r_imm_e   <= '0;
      r_ctrl_e  <= CTRL_NOP;
    end else if (i_flush_e) begin
      r_valid_e <= 1'b0;
      r_ctrl_e  <= CTRL_NOP;
    end else if (!i_stall_e) begin
      r_valid_e <= i_valid_d;
      r_op1_e   <= w_op1_d;
      r_op2_e   <= w_op2_d;
      r_ra1_e   <= i_ra1_d;
      r_ra2_e   <= i_ra2_d;
      r_wa_e    <= i_wa_d;
      r_imm_e   <= i_imm_d;
      r_ctrl_e  <= i_valid_d ? i_ctrl_d : CTRL_NOP;
    end
  end

  // A load in E whose destination is read by the instruction in D cannot be
  // forwarded in time, so decode must wait a cycle. R15 is never a real
  // load target for this purpose.
  assign o_lu_stall_d = r_valid_e && r_ctrl_e.mem_to_reg && r_ctrl_e.reg_write &&
                        ((r_wa_e == i_ra1_d) || (r_wa_e == i_ra2_d)) &&
                        (r_wa_e != AW'(REG_PC));

`ifdef ID_EX_FWD_EN
  fwd_mux #(.DW(DW), .AW(AW)) u_fwd_a (
    .i_ra_e        (r_ra1_e),
    .i_op_e        (r_op1_e),
    .i_result_m    (i_result_m),
    .i_result_w    (i_result_w),
    .i_wa_m        (i_wa_m),
    .i_wa_w        (i_wa_w),
    .i_reg_write_m (i_reg_write_m),
    .i_reg_write_w (i_reg_write_w),
    .o_src         (o_src_a_e)
  );

  fwd_mux #(.DW(DW), .AW(AW)) u_fwd_b (
    .i_ra_e        (r_ra2_e),
    .i_op_e        (r_op2_e),
    .i_result_m    (i_result_m),
    .i_result_w    (i_result_w),
    .i_wa_m        (i_wa_m),
    .i_wa_w        (i_wa_w),
    .i_reg_write_m (i_reg_write_m),
    .i_reg_write_w (i_reg_write_w),
    .o_src         (o_src_b_e)
  );
`else
  assign o_src_a_e = r_op1_e;
  assign o_src_b_e = r_op2_e;
`endif

  assign o_valid_e = r_valid_e;
  assign o_ra1_e   = r_ra1_e;
  assign o_ra2_e   = r_ra2_e;
  assign o_wa_e    = r_wa_e;
  assign o_imm_e   = r_imm_e;
  assign o_ctrl_e  = r_ctrl_e;

endmodule
